// File: rtl/audio_mix_pdm_pkg.sv
// rtl/audio_mix_pdm_pkg.sv - shared types, widths and tick helper for the voice mixer
package audio_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_e;

  localparam int ENV_MAX  = 255;
  localparam int MIX_W    = 10;
  localparam int SAMPLE_W = 10;
  localparam int ACC_W    = 10;
  localparam int PRESC_W  = 15;
  localparam int RATE_W   = 4;
  localparam int VOL_W    = 4;

  // A rate of r fires once every 2**r strobes: the low r prescaler bits must all be zero.
  function automatic logic rate_hit(input logic [PRESC_W-1:0] presc,
                                    input logic [RATE_W-1:0]  rate);
    logic [PRESC_W-1:0] mask;
    mask = (PRESC_W'(1) << rate) - PRESC_W'(1);
    return (presc & mask) == '0;
  endfunction

endpackage

// File: rtl/audio_mix_pdm_if.sv
// rtl/audio_mix_pdm_if.sv - control and output bundle between the mixer and its host
interface audio_mix_pdm_if
  import audio_pkg::*;
#(
  parameter int NVOICE = 3
);

  logic                en;
  logic [NVOICE-1:0]   voice_in;
  logic [NVOICE-1:0]   gate;
  logic [RATE_W-1:0]   attack_rate;
  logic [RATE_W-1:0]   release_rate;
  logic [VOL_W-1:0]    master_vol;
  logic [SAMPLE_W-1:0] sample_out;
  logic                pdm_out;
  logic                env_busy;

  modport master (
    output en, voice_in, gate, attack_rate, release_rate, master_vol,
    input  sample_out, pdm_out, env_busy
  );

  modport slave (
    input  en, voice_in, gate, attack_rate, release_rate, master_vol,
    output sample_out, pdm_out, env_busy
  );

endinterface

// File: rtl/audio_mix_pdm_env_gen.sv
// rtl/audio_mix_pdm_env_gen.sv - per-voice attack/sustain/release envelope
module env_gen
  import audio_pkg::*;
#(
  parameter int ENV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tick_a,
  input  logic             tick_r,
  input  logic             gate,
  output logic [ENV_W-1:0] level,
  output logic             busy
);

  localparam logic [ENV_W-1:0] LVL_MAX = ENV_W'(ENV_MAX);

  env_state_e       state_q, state_d, eff_state;
  logic [ENV_W-1:0] level_q, level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENV_IDLE;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Gate decides the state first; the level step then obeys that new state in the same strobe.
  always_comb begin
    eff_state = state_q;
    state_d   = state_q;
    level_d   = level_q;
    if (en) begin
      case (state_q)
        ENV_IDLE:    if (gate)  eff_state = ENV_ATTACK;
        ENV_ATTACK:  if (!gate) eff_state = ENV_RELEASE;
        ENV_SUSTAIN: if (!gate) eff_state = ENV_RELEASE;
        ENV_RELEASE: if (gate)  eff_state = ENV_ATTACK;
        default:     eff_state = ENV_IDLE;
      endcase

      if (eff_state == ENV_ATTACK && tick_a && level_q != LVL_MAX)
        level_d = level_q + ENV_W'(1);
      if (eff_state == ENV_RELEASE && tick_r && level_q != '0)
        level_d = level_q - ENV_W'(1);

      state_d = eff_state;
      if (eff_state == ENV_ATTACK && level_d == LVL_MAX)
        state_d = ENV_SUSTAIN;
      if (eff_state == ENV_RELEASE && level_d == '0)
        state_d = ENV_IDLE;
    end
  end

  assign level = level_q;
  assign busy  = (state_q != ENV_IDLE);

endmodule

// File: rtl/audio_mix_pdm.sv
// rtl/audio_mix_pdm.sv - envelope-gated voice mixer with master volume and sigma-delta output
module audio_mix_pdm
  import audio_pkg::*;
#(
  parameter int NVOICE = 3,
  parameter int ENV_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  audio_mix_pdm_if.slave  bus
);

  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic                   tick_a, tick_r;
  logic [ENV_W-1:0]       level [NVOICE];
  logic [NVOICE-1:0]      busy;
  logic [MIX_W-1:0]       mix_sum;
  logic [MIX_W+VOL_W-1:0] scaled;
  logic [SAMPLE_W-1:0]    sample_q, sample_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic                   pdm_q, pdm_d;
  logic [ACC_W:0]         sd_sum;

  assign tick_a  = bus.en & rate_hit(presc_q, bus.attack_rate);
  assign tick_r  = bus.en & rate_hit(presc_q, bus.release_rate);
  assign presc_d = bus.en ? presc_q + PRESC_W'(1) : presc_q;

  for (genvar i = 0; i < NVOICE; i++) begin : g_voice
    env_gen #(
      .ENV_W (ENV_W)
    ) u_env (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (bus.en),
      .tick_a (tick_a),
      .tick_r (tick_r),
      .gate   (bus.gate[i]),
      .level  (level[i]),
      .busy   (busy[i])
    );
  end

  // Mix reads the envelope registers before this strobe's update, giving one strobe of latency.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NVOICE; i++) begin
      if (bus.voice_in[i])
        mix_sum = mix_sum + MIX_W'(level[i]);
    end
    scaled   = (MIX_W+VOL_W)'(mix_sum) * (MIX_W+VOL_W)'(bus.master_vol);
    sample_d = bus.en ? scaled[MIX_W+VOL_W-1:VOL_W] : sample_q;
  end

  always_comb begin
    sd_sum = {1'b0, acc_q} + (ACC_W+1)'(sample_q);
    acc_d  = sd_sum[ACC_W-1:0];
    pdm_d  = sd_sum[ACC_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      sample_q <= '0;
      acc_q    <= '0;
      pdm_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      sample_q <= sample_d;
      acc_q    <= acc_d;
      pdm_q    <= pdm_d;
    end
  end

  assign bus.sample_out = sample_q;
  assign bus.pdm_out    = pdm_q;
  assign bus.env_busy   = |busy;

endmodule
